board_click_writer: RTL and testbench
=====================================

Name: board_click_writer

Overview:
- Write-side controller for one board_mem instance, on the control clock.
- Converts a mouse left-button press over a 12x12 grid into a single write of a cell code to the board memory port.
- Also sweeps the whole board to empty on a clear request.
- One instance per board: my board at X_POS 100, enemy board at X_POS 538.

Parameters:
- X_POS, 100, grid left edge in pixels.
- Y_POS, 200, grid top edge in pixels.
- CELL_SIZE, 32, cell edge in pixels; must be at least 1.
- X_SIZE, 12, cells per row; at most 16.
- Y_SIZE, 12, cells per column; at most 16.
- DEBOUNCE_CYCLES, 16, stable-cycle count for the optional debounce.

Ports:
- clk  in  1  control clock.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- enable  in  1  1 = accept clicks.
- mouse_x_pos  in  12  cursor x, from the mouse clock domain.
- mouse_y_pos  in  12  cursor y, from the mouse clock domain.
- mouse_left  in  1  left button level, from the mouse clock domain.
- cell_value  in  2  code to write: 0 empty, 1 ship, 2 miss, 3 hit.
- clear_req  in  1  one-cycle pulse; start the clear sweep.
- write_addr  out  8  {y_idx[3:0], x_idx[3:0]}.
- write_data  out  2  data to board_mem.
- write_enable  out  1  write strobe.
- busy  out  1  1 while in LOCATE, WRITE or CLEAR.
- click_miss  out  1  one-cycle pulse: click landed outside the grid.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; sync/edge registers 0.
- Input capture:
  - mouse_left passes through a 2-FF synchroniser, then a rising-edge detector.
  - The edge is valid only in IDLE with enable=1. Edges at any other time are dropped, not queued.
  - On a valid edge: register mouse_x_pos, mouse_y_pos and cell_value in the same cycle.
- States:
  - IDLE:
    - clear_req=1 -> CLEAR, x/y counters = 0. clear_req has priority over a same-cycle click edge; the click is dropped.
    - Valid edge, point inside the grid -> LOCATE, with remainders rx = x - X_POS, ry = y - Y_POS and indices 0.
    - Inside means X_POS <= x < X_POS+X_SIZE*CELL_SIZE and Y_POS <= y < Y_POS+Y_SIZE*CELL_SIZE, compared unsigned at 13 bits.
    - Valid edge, point outside the grid -> click_miss=1 for one cycle; stay in IDLE.
  - LOCATE (iterative division, no divider):
    - Each cycle, if rx >= CELL_SIZE then rx -= CELL_SIZE and x_idx++. Same for ry and y_idx, in parallel.
    - When both remainders < CELL_SIZE -> WRITE.
    - Takes max(x_idx, y_idx)+1 cycles, at most max(X_SIZE, Y_SIZE).
  - WRITE: one cycle with write_enable=1, write_addr={y_idx,x_idx}, write_data=captured cell_value -> IDLE.
  - CLEAR:
    - write_enable=1 and write_data=0 every cycle.
    - Address runs x 0..X_SIZE-1 inside y 0..Y_SIZE-1. Indices X_SIZE..15 are never written.
    - After address {Y_SIZE-1, X_SIZE-1} -> IDLE. X_SIZE*Y_SIZE write cycles total (144 by default).
    - clear_req during CLEAR is ignored.
- busy is registered and equals (state != IDLE).
- write_enable is 0 in IDLE and LOCATE.
- write_addr and write_data hold their last value when write_enable=0.
- Button held down gives exactly one write; the next write needs a release and a new press.
- Reset asserted mid-LOCATE or mid-CLEAR aborts immediately with no further writes. A partial clear is acceptable.

Optional Feature:
- Macro: BOARD_CLICK_DEBOUNCE_EN.
- Defined: the synchronised mouse_left feeds a debouncer. The filtered level changes only after the raw level has been stable for DEBOUNCE_CYCLES consecutive clk cycles. The edge detector uses the filtered level, so a click is accepted DEBOUNCE_CYCLES cycles later than without the macro.
- Undefined: the synchronised level goes straight to the edge detector; no debounce logic is built.

Test Plan:
- Click at (100,200), cell_value=1 -> after LOCATE (1 cycle), one write_enable pulse: addr 0x00, data 1; busy for 2 cycles.
- Click at (483,583), cell_value=3 -> LOCATE 12 cycles, then write addr 0xBB, data 3; exactly one write_enable pulse.
- Click at (484,300), then at (99,250) -> click_miss pulses twice; write_enable stays 0; busy stays 0.
- clear_req pulse -> 144 consecutive writes, data 0, addresses 0x00..0x0B, 0x10..0x1B, …, 0xB0..0xBB; busy 144 cycles. A click edge in the same cycle as clear_req is dropped.
- Second press during LOCATE, or button held for 1000 cycles -> only one write. enable=0 click -> no write, no click_miss.
- rst=0 pulse at the 50th CLEAR write -> outputs 0 asynchronously, state IDLE, no writes after deassertion. With BOARD_CLICK_DEBOUNCE_EN, a 5-cycle glitch on mouse_left -> no write.

Source files
------------

// File: rtl/board_click_writer.sv
`default_nettype none
// ============================================================================
// Module   : board_click_writer
// Purpose  : Write-side controller for one board_mem instance. Turns a mouse
//            left-button press over an X_SIZE x Y_SIZE grid into one write of
//            a cell code, and sweeps the whole board to empty on clear_req.
//            Optional macro BOARD_CLICK_DEBOUNCE_EN inserts a debouncer
//            between the button synchroniser and the rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module board_click_writer #(
  parameter int X_POS           = 100,
  parameter int Y_POS           = 200,
  parameter int CELL_SIZE       = 32,
  parameter int X_SIZE          = 12,
  parameter int Y_SIZE          = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] mouse_x_pos,
  input  logic [11:0] mouse_y_pos,
  input  logic        mouse_left,
  input  logic [1:0]  cell_value,
  input  logic        clear_req,
  output logic [7:0]  write_addr,
  output logic [1:0]  write_data,
  output logic        write_enable,
  output logic        busy,
  output logic        click_miss
);

  // Grid bounds, compared unsigned at 13 bits so edge+size cannot wrap.
  localparam logic [12:0] c_X_LO  = 13'(X_POS);
  localparam logic [12:0] c_X_HI  = 13'(X_POS + X_SIZE * CELL_SIZE);
  localparam logic [12:0] c_Y_LO  = 13'(Y_POS);
  localparam logic [12:0] c_Y_HI  = 13'(Y_POS + Y_SIZE * CELL_SIZE);
  localparam logic [12:0] c_CELL  = 13'(CELL_SIZE);
  localparam logic [3:0]  c_X_END = 4'(X_SIZE - 1);
  localparam logic [3:0]  c_Y_END = 4'(Y_SIZE - 1);

  // Reject configurations the 4-bit index fields cannot represent.
  if (CELL_SIZE < 1 || X_SIZE < 1 || X_SIZE > 16 || Y_SIZE < 1 || Y_SIZE > 16
      || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("board_click_writer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCATE = 2'd1,
    S_WRITE  = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t      state_q;
  logic        ml_s1_q;
  logic        ml_s2_q;
  logic        ml_prev_q;
  logic        w_level;
  logic        w_rise;
  logic        w_inside;
  logic [12:0] w_x13;
  logic [12:0] w_y13;
  logic [12:0] rx_q, rx_d;
  logic [12:0] ry_q, ry_d;
  logic [3:0]  xi_q, xi_d;
  logic [3:0]  yi_q, yi_d;
  logic [1:0]  val_q;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  data_q;
  logic        we_q;
  logic        busy_q;
  logic        miss_q;

  // Two-flop synchroniser for the button level from the mouse clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ml_s1_q <= 1'b0;
      ml_s2_q <= 1'b0;
    end else begin
      ml_s1_q <= mouse_left;
      ml_s2_q <= ml_s1_q;
    end
  end

`ifdef BOARD_CLICK_DEBOUNCE_EN
  localparam int          c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

  logic [c_DB_W-1:0] db_cnt_q;
  logic              ml_filt_q;

  // Filtered level follows the raw level only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q  <= '0;
      ml_filt_q <= 1'b0;
    end else if (ml_s2_q != ml_filt_q) begin
      if (db_cnt_q == c_DB_LAST) begin
        db_cnt_q  <= '0;
        ml_filt_q <= ml_s2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  assign w_level = ml_filt_q;
`else
  assign w_level = ml_s2_q;
`endif

  // Previous level for rising-edge detection; runs in every state so an
  // edge seen while busy is consumed rather than remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ml_prev_q <= 1'b0;
    end else begin
      ml_prev_q <= w_level;
    end
  end

  assign w_rise   = w_level & ~ml_prev_q;
  assign w_x13    = {1'b0, mouse_x_pos};
  assign w_y13    = {1'b0, mouse_y_pos};
  assign w_inside = (w_x13 >= c_X_LO) && (w_x13 < c_X_HI) &&
                    (w_y13 >= c_Y_LO) && (w_y13 < c_Y_HI);

  // One subtract-and-count step of the iterative division per axis, and
  // the raster-order advance of the clear sweep address.
  always_comb begin
    rx_d = rx_q;
    xi_d = xi_q;
    ry_d = ry_q;
    yi_d = yi_q;
    if (rx_q >= c_CELL) begin
      rx_d = rx_q - c_CELL;
      xi_d = xi_q + 4'd1;
    end
    if (ry_q >= c_CELL) begin
      ry_d = ry_q - c_CELL;
      yi_d = yi_q + 4'd1;
    end
    if (addr_q[3:0] == c_X_END) begin
      addr_d = {addr_q[7:4] + 4'd1, 4'd0};
    end else begin
      addr_d = {addr_q[7:4], addr_q[3:0] + 4'd1};
    end
  end

  // Main control FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      xi_q    <= '0;
      yi_q    <= '0;
      val_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      miss_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q <= S_CLEAR;
            addr_q  <= '0;
            data_q  <= 2'd0;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (w_rise && enable) begin
            if (w_inside) begin
              state_q <= S_LOCATE;
              rx_q    <= w_x13 - c_X_LO;
              ry_q    <= w_y13 - c_Y_LO;
              xi_q    <= '0;
              yi_q    <= '0;
              val_q   <= cell_value;
              busy_q  <= 1'b1;
            end else begin
              miss_q <= 1'b1;
            end
          end
        end
        S_LOCATE: begin
          rx_q <= rx_d;
          ry_q <= ry_d;
          xi_q <= xi_d;
          yi_q <= yi_d;
          if ((rx_q < c_CELL) && (ry_q < c_CELL)) begin
            state_q <= S_WRITE;
            addr_q  <= {yi_q, xi_q};
            data_q  <= val_q;
            we_q    <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_CLEAR: begin
          if (addr_q == {c_Y_END, c_X_END}) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= addr_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign click_miss   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_board_click_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_click_writer
// Purpose  : Directed self-checking bench for board_click_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_click_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] mouse_x_pos = '0;
  logic [11:0] mouse_y_pos = '0;
  logic        mouse_left = 1'b0;
  logic [1:0]  cell_value = '0;
  logic        clear_req = 1'b0;
  logic [7:0]  write_addr;
  logic [1:0]  write_data;
  logic        write_enable;
  logic        busy;
  logic        click_miss;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wr_addr_q[$];
  logic [1:0] wr_data_q[$];
  int         busy_cnt = 0;
  int         miss_cnt = 0;

  board_click_writer dut (
    .clk          (clk),
    .rst          (rst_n),
    .enable       (enable),
    .mouse_x_pos  (mouse_x_pos),
    .mouse_y_pos  (mouse_y_pos),
    .mouse_left   (mouse_left),
    .cell_value   (cell_value),
    .clear_req    (clear_req),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy         (busy),
    .click_miss   (click_miss)
  );

  always #5 clk = ~clk;

  // Observe the write port and status lines on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_enable) begin
        wr_addr_q.push_back(write_addr);
        wr_data_q.push_back(write_data);
      end
      if (busy) busy_cnt++;
      if (click_miss) miss_cnt++;
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    busy_cnt = 0;
    miss_cnt = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic click(input int x, input int y, input logic [1:0] v);
    mouse_x_pos = 12'(x);
    mouse_y_pos = 12'(y);
    cell_value  = v;
    mouse_left  = 1'b1;
    cyc(40);
    mouse_left  = 1'b0;
    cyc(40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    @(negedge clk);
    n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", write_enable); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (click_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss got %b want 0", click_miss); end
    n_checks++; if (write_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", write_addr); end
    n_checks++; if (write_data !== 2'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", write_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(2);
  endtask

  task automatic test_click_origin();
    clear_log();
    click(100, 200, 2'd1);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL origin_count got %0d want 1", wr_addr_q.size()); end
    else begin
      n_checks++; if (wr_addr_q[0] !== 8'h00) begin n_fail++; $display("FAIL origin_addr got %h want 00", wr_addr_q[0]); end
      n_checks++; if (wr_data_q[0] !== 2'd1) begin n_fail++; $display("FAIL origin_data got %0d want 1", wr_data_q[0]); end
    end
    n_checks++; if (busy_cnt !== 2) begin n_fail++; $display("FAIL origin_busy got %0d want 2", busy_cnt); end
  endtask

  task automatic test_click_corner();
    clear_log();
    click(483, 583, 2'd3);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL corner_count got %0d want 1", wr_addr_q.size()); end
    else begin
      n_checks++; if (wr_addr_q[0] !== 8'hBB) begin n_fail++; $display("FAIL corner_addr got %h want bb", wr_addr_q[0]); end
      n_checks++; if (wr_data_q[0] !== 2'd3) begin n_fail++; $display("FAIL corner_data got %0d want 3", wr_data_q[0]); end
    end
    n_checks++; if (busy_cnt !== 13) begin n_fail++; $display("FAIL corner_busy got %0d want 13", busy_cnt); end
    // Interior cell: (100+5*32+7, 200+9*32+31) -> x_idx 5, y_idx 9.
    clear_log();
    click(267, 519, 2'd2);
    n_checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 8'h95 || wr_data_q[0] !== 2'd2) begin
      n_fail++; $display("FAIL mid_cell got count %0d addr %h want count 1 addr 95 data 2",
                         wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 8'hxx);
    end
    n_checks++; if (busy_cnt !== 11) begin n_fail++; $display("FAIL mid_busy got %0d want 11", busy_cnt); end
  endtask

  task automatic test_miss();
    clear_log();
    click(484, 300, 2'd1);
    click(99, 250, 2'd1);
    click(200, 584, 2'd1);
    n_checks++; if (miss_cnt !== 3) begin n_fail++; $display("FAIL miss_pulses got %0d want 3", miss_cnt); end
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL miss_writes got %0d want 0", wr_addr_q.size()); end
    n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL miss_busy got %0d want 0", busy_cnt); end
  endtask

  task automatic test_clear();
    int bad;
    int waited;
    logic [7:0] exp_a;
    clear_log();
    mouse_x_pos = 12'd150;
    mouse_y_pos = 12'd250;
    cell_value  = 2'd1;
    mouse_left  = 1'b1;
    cyc(2);
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 400) begin
      cyc(1);
      waited++;
    end
    n_checks++; if (waited >= 400) begin n_fail++; $display("FAIL clear_timeout busy still %b after %0d cycles", busy, waited); end
    cyc(40);
    mouse_left = 1'b0;
    cyc(40);
    n_checks++; if (wr_addr_q.size() !== 144) begin n_fail++; $display("FAIL clear_count got %0d want 144", wr_addr_q.size()); end
    bad = 0;
    for (int i = 0; i < 144 && i < wr_addr_q.size(); i++) begin
      exp_a[7:4] = 4'(i / 12);
      exp_a[3:0] = 4'(i % 12);
      if (wr_addr_q[i] !== exp_a || wr_data_q[i] !== 2'd0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clear_sequence got %0d bad entries want 0", bad); end
    n_checks++; if (busy_cnt !== 144) begin n_fail++; $display("FAIL clear_busy got %0d want 144", busy_cnt); end
    n_checks++; if (miss_cnt !== 0) begin n_fail++; $display("FAIL clear_miss got %0d want 0", miss_cnt); end
    // A clear request during a sweep is ignored: still exactly 144 writes.
    clear_log();
    clear_req = 1'b1; cyc(1); clear_req = 1'b0;
    cyc(20);
    clear_req = 1'b1; cyc(1); clear_req = 1'b0;
    cyc(200);
    n_checks++; if (wr_addr_q.size() !== 144) begin n_fail++; $display("FAIL clear_reissue got %0d want 144", wr_addr_q.size()); end
  endtask

  task automatic test_single_write();
    clear_log();
    mouse_x_pos = 12'd100; mouse_y_pos = 12'd200; cell_value = 2'd2;
    mouse_left = 1'b1;
    cyc(1000);
    mouse_left = 1'b0;
    cyc(40);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL held_count got %0d want 1", wr_addr_q.size()); end
    clear_log();
    mouse_x_pos = 12'd483; mouse_y_pos = 12'd583; cell_value = 2'd3;
    mouse_left = 1'b1; cyc(4);
    mouse_left = 1'b0; cyc(2);
    mouse_left = 1'b1; cyc(40);
    mouse_left = 1'b0; cyc(40);
    n_checks++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL repress_count got %0d want 1", wr_addr_q.size()); end
  endtask

  task automatic test_disabled();
    clear_log();
    enable = 1'b0;
    click(100, 200, 2'd1);
    click(50, 50, 2'd1);
    enable = 1'b1;
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL disabled_writes got %0d want 0", wr_addr_q.size()); end
    n_checks++; if (miss_cnt !== 0) begin n_fail++; $display("FAIL disabled_miss got %0d want 0", miss_cnt); end
    n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL disabled_busy got %0d want 0", busy_cnt); end
  endtask

  task automatic test_reset_mid_clear();
    int waited;
    clear_log();
    clear_req = 1'b1; cyc(1); clear_req = 1'b0;
    waited = 0;
    while (wr_addr_q.size() < 50 && waited < 400) begin
      @(negedge clk); #1;
      waited++;
    end
    n_checks++; if (wr_addr_q.size() !== 50) begin n_fail++; $display("FAIL midrst_reach got %0d want 50", wr_addr_q.size()); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b want 0", write_enable); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (write_addr !== 8'h00) begin n_fail++; $display("FAIL midrst_addr got %h want 00", write_addr); end
    cyc(3);
    rst_n = 1'b1;
    cyc(30);
    n_checks++; if (wr_addr_q.size() !== 50) begin n_fail++; $display("FAIL midrst_after got %0d want 50", wr_addr_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b want 0", busy); end
  endtask

`ifdef BOARD_CLICK_DEBOUNCE_EN
  task automatic test_glitch();
    clear_log();
    mouse_x_pos = 12'd100; mouse_y_pos = 12'd200; cell_value = 2'd1;
    mouse_left = 1'b1; cyc(5);
    mouse_left = 1'b0; cyc(60);
    n_checks++; if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL glitch_writes got %0d want 0", wr_addr_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_click_origin();
    test_click_corner();
    test_miss();
    test_clear();
    test_single_write();
    test_disabled();
    test_reset_mid_clear();
`ifdef BOARD_CLICK_DEBOUNCE_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
